ahbl_uart_rx: RTL and testbench

AHB-Lite slave UART receiver: 8N1 framing, 16x oversampling, programmable baud prescaler and a receive FIFO. It is the receive-side counterpart of the SoC's UART transmitter and occupies a peripheral slot behind the AHB splitter. The CPU pops bytes through a memory-mapped data register. IRQ is raised while data is waiting.

---
 rtl/ahbl_uart_rx_pkg.sv | 32 +++
 rtl/ahbl_uart_rx_if.sv | 28 ++
 rtl/ahbl_uart_rx_fifo.sv | 54 +++++
 rtl/ahbl_uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_ahbl_uart_rx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_uart_rx_pkg
// Brief    : Register map, bit indices and FSM encoding for ahbl_uart_rx.
// Revision : 1.0
// ============================================================================
package ahbl_uart_rx_pkg;

  localparam logic [1:0] REG_RXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/ahbl_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_uart_rx_if
// Brief    : AHB-Lite bus bundle between the splitter (master) and the UART RX slot.
// Revision : 1.0
// ============================================================================
interface ahbl_uart_rx_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HSIZE, HWRITE, HREADY, HSEL, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HWRITE, HREADY, HSEL, HWDATA,
    output HREADYOUT, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahbl_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Synchronous byte FIFO, count register with wrap-around pointers.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire logic [WIDTH-1:0] din_i,
  output logic      [WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push, w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign dout_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/ahbl_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_uart_rx
// Brief    : AHB-Lite UART receiver, 8N1, 16x oversampling, prescaler, RX FIFO.
// Revision : 1.0
// ============================================================================
module ahbl_uart_rx
  import ahbl_uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  wire logic    HCLK,
  input  wire logic    HRESET,
  ahbl_uart_rx_if.slave bus,
  input  wire logic    rx,
  output logic         IRQ
);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE/2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  logic                  dphase_q, dwrite_q;
  logic [1:0]            daddr_q;
  logic [1:0]            ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q, pcnt_q;
  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e             state_q;
  logic [3:0]            tcnt_q;
  logic [2:0]            bit_q;
  logic [7:0]            shift_q;
  logic                  push_q, ferr_set_q;
  logic                  overrun_q, frame_err_q, irq_q;

  logic       w_accept, w_wr, w_pop, w_tick, w_en;
  logic       fifo_empty, fifo_full;
  logic [7:0] fifo_dout;
  logic       unused_ok;

  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_wr     = dphase_q & dwrite_q;
  assign w_pop    = dphase_q & ~dwrite_q & (daddr_q == REG_RXDATA) & ~fifo_empty;
  assign w_en     = ctrl_q[CTRL_EN];
  assign w_tick   = w_en & (state_q != S_IDLE) & (pcnt_q == '0);

  assign bus.HREADYOUT = 1'b1;
  assign IRQ           = irq_q;
  assign unused_ok     = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0],
                           bus.HWDATA[31:PRESCALE_W]};

  always_comb begin
    bus.HRDATA = '0;
    if (dphase_q && !dwrite_q) begin
      case (daddr_q)
        REG_RXDATA:   bus.HRDATA = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
        REG_STATUS:   bus.HRDATA = {28'd0, frame_err_q, overrun_q, fifo_full, ~fifo_empty};
        REG_CTRL:     bus.HRDATA = {30'd0, ctrl_q};
        default:      bus.HRDATA = 32'(prescale_q);
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dphase_q    <= 1'b0;
      dwrite_q    <= 1'b0;
      daddr_q     <= 2'd0;
      ctrl_q      <= 2'd0;
      prescale_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      dphase_q <= w_accept;
      if (w_accept) begin
        daddr_q  <= bus.HADDR[3:2];
        dwrite_q <= bus.HWRITE;
      end
      if (w_wr && daddr_q == REG_CTRL)     ctrl_q     <= bus.HWDATA[1:0];
      if (w_wr && daddr_q == REG_PRESCALE) prescale_q <= bus.HWDATA[PRESCALE_W-1:0];
      // New error events take precedence over a simultaneous clear.
      if (w_wr && daddr_q == REG_STATUS) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (push_q && fifo_full && !w_pop) overrun_q   <= 1'b1;
      if (ferr_set_q)                    frame_err_q <= 1'b1;
      irq_q <= ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | overrun_q | frame_err_q);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      pcnt_q    <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (!w_en || state_q == S_IDLE || w_tick) pcnt_q <= prescale_q;
      else                                      pcnt_q <= pcnt_q - 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      tcnt_q     <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      if (!w_en) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
              state_q <= S_START;
              tcnt_q  <= 4'd0;
            end
          end
          S_START: begin
            if (w_tick) begin
              if (tcnt_q == TICK_MID) begin
                tcnt_q  <= 4'd0;
                bit_q   <= 3'd0;
                state_q <= rx_sync_q ? S_IDLE : S_DATA;
              end else begin
                tcnt_q <= tcnt_q + 1'b1;
              end
            end
          end
          S_DATA: begin
            if (w_tick) begin
              if (tcnt_q == TICK_LAST) begin
                tcnt_q  <= 4'd0;
                shift_q <= {rx_sync_q, shift_q[7:1]};
                bit_q   <= bit_q + 1'b1;
                if (bit_q == 3'd7) state_q <= S_STOP;
              end else begin
                tcnt_q <= tcnt_q + 1'b1;
              end
            end
          end
          default: begin
            if (w_tick) begin
              if (tcnt_q == TICK_LAST) begin
                tcnt_q     <= 4'd0;
                state_q    <= S_IDLE;
                push_q     <= rx_sync_q;
                ferr_set_q <= ~rx_sync_q;
              end else begin
                tcnt_q <= tcnt_q + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push_q),
    .pop_i   (w_pop),
    .din_i   (shift_q),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
endmodule
`default_nettype wire

// File: tb/tb_ahbl_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_uart_rx
// Brief    : Self-checking bench for ahbl_uart_rx with a queue-based FIFO model.
// Revision : 1.0
// ============================================================================
module tb_ahbl_uart_rx;
  import ahbl_uart_rx_pkg::*;

  localparam int BT = 16 * (3 + 1);

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic rx = 1'b1;
  logic IRQ;

  ahbl_uart_rx_if bus ();

  ahbl_uart_rx #(
    .FIFO_DEPTH (8),
    .PRESCALE_W (16)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus),
    .rx     (rx),
    .IRQ    (IRQ)
  );

  always #5 HCLK = ~HCLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ovr = 1'b0;
  logic        exp_fe  = 1'b0;
  logic [31:0] rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ahb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rdata);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a; bus.HWRITE = wr;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = wd;
    rdata = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    ahb_xfer(a, 1'b1, d, dummy);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    ahb_xfer(a, 1'b0, 32'd0, d);
  endtask

  function automatic logic [31:0] model_status();
    return {28'd0, exp_fe, exp_ovr, exp_q.size() == 8, exp_q.size() != 0};
  endfunction

  task automatic check_status(input string tag);
    logic [31:0] d;
    ahb_read(32'h4, d);
    check_eq(tag, d, model_status());
  endtask

  task automatic clear_status();
    ahb_write(32'h4, 32'h0);
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    ahb_read(32'h0, d);
    e = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
    check_eq(tag, d, e);
  endtask

  task automatic drive_bits(input logic [7:0] d, input int nbits);
    rx = 1'b0;
    repeat (BT) @(posedge HCLK);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (BT) @(posedge HCLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    drive_bits(d, 8);
    rx = stop_ok;
    repeat (BT) @(posedge HCLK);
    rx = 1'b1;
    repeat (8) @(posedge HCLK);
    if (!stop_ok)                exp_fe = 1'b1;
    else if (exp_q.size() < 8)   exp_q.push_back(d);
    else                         exp_ovr = 1'b1;
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWRITE = 1'b0;
    bus.HREADY = 1'b1; bus.HSIZE = 3'b010; bus.HWDATA = '0;
    repeat (4) @(posedge HCLK);
    #1 HRESET = 1'b0;

    check_eq("rst_irq", 32'(IRQ), 32'd0);
    check_eq("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check_eq("rst_hrdata", bus.HRDATA, 32'd0);
    read_data("rst_rxdata");
    check_status("rst_status");
    ahb_read(32'h8, rd); check_eq("rst_ctrl", rd, 32'd0);
    ahb_read(32'hC, rd); check_eq("rst_prescale", rd, 32'd0);

    ahb_write(32'h8, 32'h3);
    ahb_write(32'hC, 32'h3);
    ahb_read(32'h8, rd); check_eq("ctrl_rb", rd, 32'h3);
    ahb_read(32'hC, rd); check_eq("prescale_rb", rd, 32'h3);

    // Single byte, with a bounded wait for IRQ during the stop bit.
    drive_bits(8'hA5, 8);
    rx = 1'b1;
    waited = 0;
    while (!IRQ && waited < BT) begin
      @(posedge HCLK); #1;
      waited++;
    end
    check_eq("irq_rise", 32'(IRQ), 32'd1);
    repeat (BT - waited + 8) @(posedge HCLK);
    exp_q.push_back(8'hA5);
    check_status("a5_status");
    read_data("a5_data");
    check_status("a5_status_after");
    repeat (3) @(posedge HCLK); #1;
    check_eq("irq_fall", 32'(IRQ), 32'd0);

    // Overrun: nine bytes into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    check_status("ovr_status_full");
    for (int i = 0; i < 8; i++) read_data("ovr_data");
    check_status("ovr_status_drained");
    clear_status();
    check_status("ovr_status_clr");

    // Framing error, then recovery.
    send_frame(8'h3C, 1'b0);
    check_status("fe_status");
    clear_status();
    check_status("fe_status_clr");
    send_frame(8'h5A, 1'b1);
    read_data("fe_next_data");

    // Short glitch must be rejected as a false start.
    rx = 1'b0;
    repeat (20) @(posedge HCLK);
    rx = 1'b1;
    repeat (3 * BT) @(posedge HCLK); #1;
    check_status("glitch_status");
    check_eq("glitch_irq", 32'(IRQ), 32'd0);
    send_frame(8'h77, 1'b1);
    read_data("glitch_next_data");

    // Reset in the middle of bit 4.
    drive_bits(8'h99, 4);
    rx = 1'b1;
    repeat (BT / 2) @(posedge HCLK);
    #1 HRESET = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    ahb_read(32'h8, rd); check_eq("mid_rst_ctrl", rd, 32'd0);
    ahb_write(32'h8, 32'h3);
    ahb_write(32'hC, 32'h3);
    send_frame(8'hC3, 1'b1);
    check_status("mid_rst_status");
    read_data("mid_rst_data");
    check_status("mid_rst_empty");

    // EN cleared mid-frame: the partial byte is discarded.
    drive_bits(8'h00, 3);
    ahb_write(32'h8, 32'h2);
    rx = 1'b1;
    repeat (8 * BT) @(posedge HCLK);
    ahb_write(32'h8, 32'h3);
    repeat (10) @(posedge HCLK); #1;
    check_status("en_clr_status");
    check_eq("en_clr_irq", 32'(IRQ), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
